// File: rtl/rc4_keyspace_scheduler_if.sv
// Bus interface for rc4_keyspace_scheduler: search control, per-core key/restart lanes and results.
// The scheduler connects through the slave modport; the controlling side uses master.
interface rc4_keyspace_scheduler_if #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned KEY_W     = 22
);
   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

   logic                       start;
   logic [KEY_W-1:0]           key_first;
   logic [KEY_W-1:0]           key_last;
   logic [NUM_CORES-1:0]       core_done;
   logic [NUM_CORES-1:0]       core_valid;
   logic [NUM_CORES*KEY_W-1:0] core_key;
   logic [NUM_CORES-1:0]       core_rst;
   logic                       busy;
   logic                       solved;
   logic                       exhausted;
   logic [KEY_W-1:0]           solved_key;
   logic [IDX_W-1:0]           solved_core;
   logic [KEY_W:0]             keys_tried;

   modport master (
      output start, key_first, key_last, core_done, core_valid,
      input  core_key, core_rst, busy, solved, exhausted, solved_key, solved_core, keys_tried
   );

   modport slave (
      input  start, key_first, key_last, core_done, core_valid,
      output core_key, core_rst, busy, solved, exhausted, solved_key, solved_core, keys_tried
   );
endinterface

// File: rtl/rc4_keyspace_scheduler.sv
// Interleaved key-space scheduler feeding NUM_CORES RC4 decrypt cores from [key_first, key_last].
// Optional completed-key counter on keys_tried is built only when KEYSCHED_STATS_EN is defined.
module rc4_keyspace_scheduler #(
   parameter int unsigned NUM_CORES = 4,
   parameter int unsigned KEY_W     = 22,
   parameter int unsigned PULSE_W   = 2
) (
   input logic clk,
   input logic rst,
   rc4_keyspace_scheduler_if.slave bus
);
   localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam int unsigned EXT_W = KEY_W + 1;
   localparam int unsigned CNT_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_SOLVED, ST_EXHAUSTED} top_state_t;
   typedef enum logic [1:0] {CS_OFF, CS_PULSE, CS_WAIT} core_state_t;

   top_state_t           state;
   core_state_t          cst     [NUM_CORES];
   logic [CNT_W-1:0]     pcnt    [NUM_CORES];
   logic [KEY_W-1:0]     key     [NUM_CORES];
   logic [KEY_W-1:0]     last_q;
   logic [NUM_CORES-1:0] core_rst_q;
   logic                 busy_q;
   logic                 solved_q;
   logic                 exhausted_q;
   logic [KEY_W-1:0]     solved_key_q;
   logic [IDX_W-1:0]     solved_core_q;

   logic [NUM_CORES-1:0] accept_c;
   logic [NUM_CORES-1:0] miss_c;
   logic [NUM_CORES-1:0] reload_c;
   logic [NUM_CORES-1:0] in_range_c;
   logic [EXT_W-1:0]     step_key_c [NUM_CORES];
   logic [EXT_W-1:0]     init_key_c [NUM_CORES];
   logic                 win_c;
   logic [IDX_W-1:0]     win_idx_c;
   logic [KEY_W-1:0]     win_key_c;
   logic                 active_c;
   logic                 empty_c;

   // Per-core done qualification, lowest-index winner, and lookahead for "all cores going OFF".
   // All range arithmetic is KEY_W+1 bits wide so a range ending at the top key never wraps.
   always_comb begin
      accept_c   = '0;
      miss_c     = '0;
      reload_c   = '0;
      in_range_c = '0;
      win_c      = 1'b0;
      win_idx_c  = '0;
      win_key_c  = '0;
      active_c   = 1'b0;
      empty_c    = bus.key_first > bus.key_last;
      for (int i = 0; i < NUM_CORES; i++) begin
         step_key_c[i] = {1'b0, key[i]} + EXT_W'(NUM_CORES);
         init_key_c[i] = {1'b0, bus.key_first} + EXT_W'(i);
         in_range_c[i] = init_key_c[i] <= {1'b0, bus.key_last};
         accept_c[i]   = (state == ST_RUN) && (cst[i] == CS_WAIT) && bus.core_done[i];
         miss_c[i]     = accept_c[i] && !bus.core_valid[i];
         reload_c[i]   = step_key_c[i] <= {1'b0, last_q};
         if (accept_c[i] && bus.core_valid[i] && !win_c) begin
            win_c     = 1'b1;
            win_idx_c = IDX_W'(i);
            win_key_c = key[i];
         end
         if ((cst[i] == CS_PULSE) || ((cst[i] == CS_WAIT) && !miss_c[i]) ||
             (miss_c[i] && reload_c[i])) begin
            active_c = 1'b1;
         end
      end
   end

   // Top FSM plus the per-core OFF/PULSE/WAIT machines and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= ST_IDLE;
         last_q        <= '0;
         core_rst_q    <= '0;
         busy_q        <= 1'b0;
         solved_q      <= 1'b0;
         exhausted_q   <= 1'b0;
         solved_key_q  <= '0;
         solved_core_q <= '0;
         for (int i = 0; i < NUM_CORES; i++) begin
            cst[i]  <= CS_OFF;
            pcnt[i] <= '0;
            key[i]  <= '0;
         end
      end else begin
         case (state)
            ST_RUN: begin
               if (win_c) begin
                  state         <= ST_SOLVED;
                  busy_q        <= 1'b0;
                  solved_q      <= 1'b1;
                  solved_key_q  <= win_key_c;
                  solved_core_q <= win_idx_c;
                  core_rst_q    <= '1;
                  for (int i = 0; i < NUM_CORES; i++) cst[i] <= CS_OFF;
               end else if (!active_c) begin
                  state       <= ST_EXHAUSTED;
                  busy_q      <= 1'b0;
                  exhausted_q <= 1'b1;
                  core_rst_q  <= '1;
                  for (int i = 0; i < NUM_CORES; i++) cst[i] <= CS_OFF;
               end else begin
                  for (int i = 0; i < NUM_CORES; i++) begin
                     case (cst[i])
                        CS_PULSE: begin
                           if (pcnt[i] == CNT_W'(PULSE_W - 1)) begin
                              cst[i]        <= CS_WAIT;
                              core_rst_q[i] <= 1'b0;
                           end else begin
                              pcnt[i] <= pcnt[i] + CNT_W'(1);
                           end
                        end
                        CS_WAIT: begin
                           if (miss_c[i]) begin
                              if (reload_c[i]) begin
                                 key[i]        <= step_key_c[i][KEY_W-1:0];
                                 cst[i]        <= CS_PULSE;
                                 pcnt[i]       <= '0;
                                 core_rst_q[i] <= 1'b1;
                              end else begin
                                 cst[i] <= CS_OFF;
                              end
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: begin
               if (bus.start) begin
                  // An inverted range skips RUN and reports exhaustion right away.
                  state         <= empty_c ? ST_EXHAUSTED : ST_RUN;
                  busy_q        <= !empty_c;
                  exhausted_q   <= empty_c;
                  solved_q      <= 1'b0;
                  solved_key_q  <= '0;
                  solved_core_q <= '0;
                  last_q        <= bus.key_last;
                  for (int i = 0; i < NUM_CORES; i++) begin
                     pcnt[i] <= '0;
                     if (in_range_c[i] && !empty_c) begin
                        key[i]        <= init_key_c[i][KEY_W-1:0];
                        cst[i]        <= CS_PULSE;
                        core_rst_q[i] <= 1'b1;
                     end else begin
                        key[i]        <= '0;
                        cst[i]        <= CS_OFF;
                        core_rst_q[i] <= empty_c;
                     end
                  end
               end
            end
         endcase
      end
   end

   always_comb begin
      bus.core_key = '0;
      for (int i = 0; i < NUM_CORES; i++) bus.core_key[i*KEY_W +: KEY_W] = key[i];
   end

   assign bus.core_rst    = core_rst_q;
   assign bus.busy        = busy_q;
   assign bus.solved      = solved_q;
   assign bus.exhausted   = exhausted_q;
   assign bus.solved_key  = solved_key_q;
   assign bus.solved_core = solved_core_q;

`ifdef KEYSCHED_STATS_EN
   localparam int unsigned POP_W = $clog2(NUM_CORES + 1);
   localparam int unsigned SUM_W = EXT_W + 1;

   logic [POP_W-1:0] done_cnt_c;
   logic [SUM_W-1:0] tried_sum_c;
   logic [EXT_W-1:0] tried_q;

   // Popcount of accepted completions this cycle, added with saturation.
   always_comb begin
      done_cnt_c = '0;
      for (int i = 0; i < NUM_CORES; i++) done_cnt_c = done_cnt_c + POP_W'(accept_c[i]);
      tried_sum_c = SUM_W'(tried_q) + SUM_W'(done_cnt_c);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tried_q <= '0;
      end else if (bus.start && (state != ST_RUN)) begin
         tried_q <= '0;
      end else if (|accept_c) begin
         tried_q <= tried_sum_c[EXT_W] ? '1 : tried_sum_c[EXT_W-1:0];
      end
   end

   assign bus.keys_tried = tried_q;
`else
   assign bus.keys_tried = '0;
`endif
endmodule

// File: tb/tb_rc4_keyspace_scheduler.sv
// Scoreboard bench for rc4_keyspace_scheduler (NUM_CORES=4, KEY_W=22, PULSE_W=2).
// Stimulus queues expected key-load, result and snapshot records; the monitor checks them as they occur.
module tb_rc4_keyspace_scheduler;
   localparam int unsigned NC = 4;
   localparam int unsigned KW = 22;
   localparam int unsigned PW = 2;
`ifdef KEYSCHED_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct {
      string       name;
      logic [87:0] key;
      logic [87:0] key_mask;
      logic [3:0]  crst;
      logic        busy;
      logic        solved;
      logic        exh;
      logic [21:0] skey;
      logic [1:0]  score;
      logic [22:0] tried;
      logic        chk_tried;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   bit   stim_done = 1'b0;
   exp_t load_q[$];
   exp_t res_q[$];
   exp_t snap_q[$];

   rc4_keyspace_scheduler_if #(.NUM_CORES(NC), .KEY_W(KW)) bus ();

   rc4_keyspace_scheduler #(.NUM_CORES(NC), .KEY_W(KW), .PULSE_W(PW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [87:0] k4(input int k3, input int k2, input int k1, input int k0);
      return {22'(k3), 22'(k2), 22'(k1), 22'(k0)};
   endfunction

   function automatic logic [22:0] tr(input int n);
      return STATS ? 23'(n) : 23'd0;
   endfunction

   function automatic exp_t mk(input string nm, input logic [87:0] key, input logic [3:0] crst,
                               input logic busy, input logic solved, input logic exh,
                               input int skey, input int score, input logic [22:0] tried);
      exp_t e;
      e.name = nm; e.key = key; e.key_mask = '1; e.crst = crst; e.busy = busy;
      e.solved = solved; e.exh = exh; e.skey = 22'(skey); e.score = 2'(score);
      e.tried = tried; e.chk_tried = 1'b1;
      return e;
   endfunction

   task automatic check(input exp_t e, input string kind);
      bit ok;
      vectors++;
      ok = (((bus.core_key ^ e.key) & e.key_mask) == '0) && (bus.core_rst == e.crst) &&
           (bus.busy == e.busy) && (bus.solved == e.solved) && (bus.exhausted == e.exh) &&
           (bus.solved_key == e.skey) && (bus.solved_core == e.score) &&
           (!e.chk_tried || (bus.keys_tried == e.tried));
      if (!ok) begin
         miscompares++;
         $display("FAIL %s/%s: got key=%h rst=%b busy=%b solved=%b exh=%b skey=%0d core=%0d tried=%0d; want key=%h rst=%b busy=%b solved=%b exh=%b skey=%0d core=%0d tried=%0d",
                  kind, e.name, bus.core_key & e.key_mask, bus.core_rst, bus.busy, bus.solved,
                  bus.exhausted, bus.solved_key, bus.solved_core, bus.keys_tried,
                  e.key & e.key_mask, e.crst, e.busy, e.solved, e.exh, e.skey, e.score, e.tried);
      end
   endtask

   // Monitor: key loads, result rises, queued snapshots and restart pulse widths.
   logic [3:0] prev_rst = '0;
   logic       prev_busy = 1'b0;
   logic       prev_fin = 1'b0;
   int         pcnt [NC];
   initial for (int i = 0; i < NC; i++) pcnt[i] = 0;

   always @(negedge clk) begin
      logic [3:0] rise;
      exp_t e;
      rise = bus.busy ? (bus.core_rst & ~(prev_busy ? prev_rst : 4'b0)) : 4'b0;
      if (rise != 4'b0) begin
         if (load_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL load/unexpected: got rise=%b key=%h, want no load", rise, bus.core_key);
         end else begin
            e = load_q.pop_front();
            check(e, "load");
         end
      end
      if ((bus.solved || bus.exhausted) && !prev_fin) begin
         if (res_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL result/unexpected: got solved=%b exh=%b, want no result", bus.solved, bus.exhausted);
         end else begin
            e = res_q.pop_front();
            check(e, "result");
         end
      end
      if (snap_q.size() != 0) begin
         e = snap_q.pop_front();
         check(e, "snap");
      end
      for (int i = 0; i < NC; i++) begin
         if (!bus.busy) pcnt[i] = 0;
         else if (bus.core_rst[i]) pcnt[i]++;
         else if (pcnt[i] != 0) begin
            vectors++;
            if (pcnt[i] != PW) begin
               miscompares++;
               $display("FAIL pulse_width core%0d: got %0d cycles, want %0d", i, pcnt[i], PW);
            end
            pcnt[i] = 0;
         end
      end
      prev_rst  = bus.core_rst;
      prev_busy = bus.busy;
      prev_fin  = bus.solved || bus.exhausted;
      if (stim_done) begin
         foreach (load_q[i]) begin vectors++; miscompares++; $display("FAIL load/%s: got nothing, want key load", load_q[i].name); end
         foreach (res_q[i])  begin vectors++; miscompares++; $display("FAIL result/%s: got nothing, want result", res_q[i].name); end
         foreach (snap_q[i]) begin vectors++; miscompares++; $display("FAIL snap/%s: got nothing, want snapshot", snap_q[i].name); end
         $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of stimulus, want completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic go(input int first, input int last);
      bus.key_first = 22'(first);
      bus.key_last  = 22'(last);
      bus.start     = 1'b1;
      tick();
      bus.start     = 1'b0;
   endtask

   task automatic strobe(input logic [3:0] done, input logic [3:0] valid);
      bus.core_done  = done;
      bus.core_valid = valid;
      tick();
      bus.core_done  = '0;
      bus.core_valid = '0;
   endtask

   initial begin
      exp_t e;
      bus.start = 1'b0; bus.key_first = '0; bus.key_last = '0;
      bus.core_done = '0; bus.core_valid = '0;

      // Reset values, then range 0..7: first load, two all-miss rounds, exhaustion.
      snap_q.push_back(mk("reset", '0, 4'h0, 0, 0, 0, 0, 0, tr(0)));
      tick(2);
      rst = 1'b0;
      tick();
      load_q.push_back(mk("r0_7_first", k4(3, 2, 1, 0), 4'hF, 1, 0, 0, 0, 0, tr(0)));
      go(0, 7);
      tick(4);
      load_q.push_back(mk("r0_7_second", k4(7, 6, 5, 4), 4'hF, 1, 0, 0, 0, 0, tr(4)));
      strobe(4'hF, 4'h0);
      tick(4);
      res_q.push_back(mk("r0_7_exhaust", k4(7, 6, 5, 4), 4'hF, 0, 0, 1, 0, 0, tr(8)));
      strobe(4'hF, 4'h0);
      tick(2);

      // Range 100..200: one staggered reload, then cores 1 and 3 hit together.
      load_q.push_back(mk("r100_first", k4(103, 102, 101, 100), 4'hF, 1, 0, 0, 0, 0, tr(0)));
      go(100, 200);
      tick(4);
      load_q.push_back(mk("r100_core0", k4(103, 102, 101, 104), 4'h1, 1, 0, 0, 0, 0, tr(1)));
      strobe(4'h1, 4'h0);
      tick(4);
      e = mk("r100_solve", k4(103, 102, 101, 104), 4'hF, 0, 1, 0, 101, 1, tr(0));
      e.chk_tried = 1'b0;
      res_q.push_back(e);
      strobe(4'hA, 4'hA);
      tick(3);
      e.name = "r100_held";
      snap_q.push_back(e);
      tick(2);

      // Range at the top of the key space: core 3 idle, no wrap to key 0.
      e = mk("top_first", k4(0, 4194303, 4194302, 4194301), 4'h7, 1, 0, 0, 0, 0, tr(0));
      e.key_mask = {22'h0, {66{1'b1}}};
      load_q.push_back(e);
      go(4194301, 4194303);
      tick(4);
      e = mk("top_exhaust", k4(0, 4194303, 4194302, 4194301), 4'hF, 0, 0, 1, 0, 0, tr(3));
      e.key_mask = {22'h0, {66{1'b1}}};
      res_q.push_back(e);
      strobe(4'hF, 4'h0);
      tick(2);

      // start ignored in RUN, async reset mid-pulse, then an inverted range.
      load_q.push_back(mk("rst_first", k4(3, 2, 1, 0), 4'hF, 1, 0, 0, 0, 0, tr(0)));
      go(0, 7);
      tick(4);
      go(50, 60);
      snap_q.push_back(mk("start_ignored", k4(3, 2, 1, 0), 4'h0, 1, 0, 0, 0, 0, tr(0)));
      tick();
      load_q.push_back(mk("rst_core2", k4(3, 6, 1, 0), 4'h4, 1, 0, 0, 0, 0, tr(1)));
      strobe(4'h4, 4'h0);
      tick();
      rst = 1'b1;
      snap_q.push_back(mk("rst_mid_pulse", '0, 4'h0, 0, 0, 0, 0, 0, tr(0)));
      tick(2);
      rst = 1'b0;
      tick();
      res_q.push_back(mk("inverted_range", '0, 4'hF, 0, 0, 1, 0, 0, tr(0)));
      go(10, 5);
      snap_q.push_back(mk("inverted_1cyc", '0, 4'hF, 0, 0, 1, 0, 0, tr(0)));
      tick(2);

      // core_done during PULSE is ignored; later a single-core hit on core 2.
      load_q.push_back(mk("pulse_first", k4(23, 22, 21, 20), 4'hF, 1, 0, 0, 0, 0, tr(0)));
      go(20, 40);
      strobe(4'hF, 4'h5);
      snap_q.push_back(mk("pulse_ignore", k4(23, 22, 21, 20), 4'hF, 1, 0, 0, 0, 0, tr(0)));
      tick(4);
      load_q.push_back(mk("pulse_second", k4(27, 26, 25, 24), 4'hF, 1, 0, 0, 0, 0, tr(4)));
      strobe(4'hF, 4'h0);
      tick();
      snap_q.push_back(mk("pulse_count4", k4(27, 26, 25, 24), 4'hF, 1, 0, 0, 0, 0, tr(4)));
      tick(4);
      res_q.push_back(mk("pulse_solve", k4(27, 26, 25, 24), 4'hF, 0, 1, 0, 26, 2, tr(5)));
      strobe(4'h4, 4'h4);
      tick(3);

      stim_done = 1'b1;
   end
endmodule
